// File: rtl/regfile_mp_pkg.sv
// Shared defaults and constants for the multi-port register file.
package regfile_mp_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_MAX_PEND = 4;
    localparam int ZERO_REG     = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: busy bits, outstanding count and sticky overflow flag.
// State updates one cycle after request; no backpressure, overflowing reserves are dropped and flagged.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int CNT_W    = $clog2(MAX_PEND+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveAddr,
    input  logic              wrEnB,
    input  logic [ADDR_W-1:0] wrAddrB,
    output logic [DEPTH-1:0]  busy,
    output logic [CNT_W-1:0]  pendCount,
    output logic              pendFull,
    output logic              ovfErr
);
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic resv_req;
    logic clr;
    logic same;
    logic accept;
    logic dec;
    logic ovf_set;

    assign pendFull = (pendCount == CNT_W'(MAX_PEND));
    assign resv_req = reserveEn && (reserveAddr != ZADDR);
    assign clr      = wrEnB && (wrAddrB != ZADDR) && busy[wrAddrB];
    // Reserve and load return on the same register: clear then re-reserve nets to no change.
    assign same     = resv_req && clr && (reserveAddr == wrAddrB);
    assign accept   = resv_req && !busy[reserveAddr] && (!pendFull || clr);
    assign dec      = clr && !same;
    assign ovf_set  = resv_req && pendFull && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            pendCount <= '0;
            ovfErr    <= 1'b0;
        end else begin
            if (dec)
                busy[wrAddrB] <= 1'b0;
            if (accept)
                busy[reserveAddr] <= 1'b1;
            pendCount <= pendCount + CNT_W'(accept) - CNT_W'(dec);
            if (ovf_set)
                ovfErr <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with write-to-read bypass and load scoreboard.
// Reads combinational, writes land on next clk edge; no backpressure.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    output logic [NUM_RD-1:0]          rdBusy,
    input  logic                       wrEnA,
    input  logic [ADDR_W-1:0]          wrAddrA,
    input  logic [DATA_W-1:0]          wrDataA,
    input  logic                       wrEnB,
    input  logic [ADDR_W-1:0]          wrAddrB,
    input  logic [DATA_W-1:0]          wrDataB,
    input  logic                       reserveEn,
    input  logic [ADDR_W-1:0]          reserveAddr,
    output logic [$clog2(MAX_PEND+1)-1:0] pendCount,
    output logic                       pendFull,
    output logic                       ovfErr
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .reserveEn   (reserveEn),
        .reserveAddr (reserveAddr),
        .wrEnB       (wrEnB),
        .wrAddrB     (wrAddrB),
        .busy        (busy),
        .pendCount   (pendCount),
        .pendFull    (pendFull),
        .ovfErr      (ovfErr)
    );

    // Port B wins on an address collision; entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                mem[r] <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (wrEnB && (wrAddrB == ADDR_W'(r)))
                    mem[r] <= wrDataB;
                else if (wrEnA && (wrAddrA == ADDR_W'(r)))
                    mem[r] <= wrDataA;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_b;
        logic              hit_a;

        assign ra    = rdAddr[i*ADDR_W +: ADDR_W];
        assign hit_b = wrEnB && (wrAddrB == ra);
        assign hit_a = wrEnA && (wrAddrA == ra);

        always_comb begin
            rdData[i*DATA_W +: DATA_W] = mem[ra];
            if (ra == ZADDR)
                rdData[i*DATA_W +: DATA_W] = '0;
            else if (hit_b)
                rdData[i*DATA_W +: DATA_W] = wrDataB;
            else if (hit_a)
                rdData[i*DATA_W +: DATA_W] = wrDataA;
        end

        // A load returning this cycle is forwarded, so it no longer counts as busy.
        assign rdBusy[i] = busy[ra] && !hit_b;
    end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic [1:0]  rdBusy;
    logic        wrEnA, wrEnB, reserveEn;
    logic [4:0]  wrAddrA, wrAddrB, reserveAddr;
    logic [31:0] wrDataA, wrDataB;
    logic [2:0]  pendCount;
    logic        pendFull, ovfErr;

    int errors = 0;
    int checks = 0;

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
        .rdBusy      (rdBusy),
        .wrEnA       (wrEnA),
        .wrAddrA     (wrAddrA),
        .wrDataA     (wrDataA),
        .wrEnB       (wrEnB),
        .wrAddrB     (wrAddrB),
        .wrDataB     (wrDataB),
        .reserveEn   (reserveEn),
        .reserveAddr (reserveAddr),
        .pendCount   (pendCount),
        .pendFull    (pendFull),
        .ovfErr      (ovfErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; one tick spans one rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wrEnA = 0; wrEnB = 0; reserveEn = 0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rdAddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wrAddrA = 0; wrAddrB = 0; reserveAddr = 0;
        wrDataA = 0; wrDataB = 0;
        set_rd(1, 2);
        #3;
        check("rst_rd0", rdData[31:0], 0);
        check("rst_cnt", pendCount, 0);
        check("rst_full", pendFull, 0);
        check("rst_ovf", ovfErr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // basic writes and reads
        wrEnA = 1; wrAddrA = 1; wrDataA = 16;
        tick();
        wrAddrA = 2; wrDataA = 22;
        tick();
        idle();
        set_rd(1, 2);
        #1;
        check("rd_r1", rdData[31:0], 16);
        check("rd_r2", rdData[63:32], 22);
        set_rd(0, 2);
        #1;
        check("rd_r0", rdData[31:0], 0);

        // write to r0 ignored; same-cycle bypass
        wrEnA = 1; wrAddrA = 0; wrDataA = 99;
        tick();
        idle();
        #1;
        check("r0_after_wr", rdData[31:0], 0);
        wrEnA = 1; wrAddrA = 3; wrDataA = 10;
        set_rd(3, 1);
        #1;
        check("bypass_a", rdData[31:0], 10);
        check("no_bypass_p1", rdData[63:32], 16);
        tick();
        idle();
        #1;
        check("r3_stored", rdData[31:0], 10);

        // write collision, port B wins
        wrEnA = 1; wrAddrA = 5; wrDataA = 7;
        wrEnB = 1; wrAddrB = 5; wrDataB = 9;
        set_rd(5, 0);
        #1;
        check("bypass_b_prio", rdData[31:0], 9);
        tick();
        idle();
        #1;
        check("collide_r5", rdData[31:0], 9);

        // fill reservations
        reserveEn = 1;
        reserveAddr = 4; tick();
        reserveAddr = 6; tick();
        reserveAddr = 7; tick();
        reserveAddr = 8; tick();
        idle();
        set_rd(6, 9);
        #1;
        check("cnt_4", pendCount, 4);
        check("full_1", pendFull, 1);
        check("ovf_0", ovfErr, 0);
        check("busy_r6", rdBusy[0], 1);

        // overflow reserve
        reserveEn = 1; reserveAddr = 9;
        tick();
        idle();
        #1;
        check("ovf_cnt", pendCount, 4);
        check("ovf_set", ovfErr, 1);
        check("ovf_r9_notbusy", rdBusy[1], 0);

        // load return on r6, forwarded and reported not busy in-cycle
        wrEnB = 1; wrAddrB = 6; wrDataB = 3;
        #1;
        check("ret_busy_bypass", rdBusy[0], 0);
        check("ret_data_bypass", rdData[31:0], 3);
        tick();
        idle();
        #1;
        check("ret_cnt", pendCount, 3);
        check("ret_busy", rdBusy[0], 0);
        check("ret_full", pendFull, 0);
        check("ret_data", rdData[31:0], 3);

        // refill, then reserve + return on different regs while full
        reserveEn = 1; reserveAddr = 6;
        tick();
        idle();
        reserveEn = 1; reserveAddr = 9;
        wrEnB = 1; wrAddrB = 4; wrDataB = 1;
        tick();
        idle();
        set_rd(9, 4);
        #1;
        check("swap_cnt", pendCount, 4);
        check("swap_full", pendFull, 1);
        check("swap_r9_busy", rdBusy[0], 1);
        check("swap_r4_free", rdBusy[1], 0);
        check("swap_r4_data", rdData[63:32], 1);

        // ALU write to busy register keeps it busy
        wrEnA = 1; wrAddrA = 7; wrDataA = 55;
        tick();
        idle();
        set_rd(7, 8);
        #1;
        check("alu_busy_data", rdData[31:0], 55);
        check("alu_busy_kept", rdBusy[0], 1);

        // reserve + return on same register
        reserveEn = 1; reserveAddr = 8;
        wrEnB = 1; wrAddrB = 8; wrDataB = 77;
        tick();
        idle();
        #1;
        check("same_cnt", pendCount, 4);
        check("same_busy", rdBusy[1], 1);
        check("same_data", rdData[63:32], 77);

        // drop to 3, then reserve an already-busy register
        wrEnB = 1; wrAddrB = 9; wrDataB = 2;
        tick();
        idle();
        reserveEn = 1; reserveAddr = 7;
        tick();
        idle();
        #1;
        check("dup_cnt", pendCount, 3);
        check("dup_busy", rdBusy[0], 1);

        // asynchronous reset mid-cycle
        #1;
        rst = 1'b1;
        #1;
        check("arst_cnt", pendCount, 0);
        check("arst_full", pendFull, 0);
        check("arst_ovf", ovfErr, 0);
        check("arst_r7", rdData[31:0], 0);
        check("arst_busy", rdBusy[0], 0);
        @(negedge clk);
        rst = 1'b0;
        wrEnB = 1; wrAddrB = 7; wrDataB = 5;
        tick();
        idle();
        #1;
        check("post_rst_r7", rdData[31:0], 5);
        check("post_rst_cnt", pendCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width, with DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning the number of independent read ports (1..4).
REQ-004 The block SHALL have parameter MAX_PEND, default 4, meaning the maximum number of outstanding load reservations.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port rdAddr, input, NUM_RD*ADDR_W bits: read addresses, with port i at slice [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rdData, output, NUM_RD*DATA_W bits: read data, combinational.
REQ-009 The block SHALL have port rdBusy, output, NUM_RD bits: addressed register has a pending load.
REQ-010 The block SHALL have ports wrEnA (1 bit), wrAddrA (ADDR_W bits) and wrDataA (DATA_W bits), all inputs: ALU write port.
REQ-011 The block SHALL have ports wrEnB (1 bit), wrAddrB (ADDR_W bits) and wrDataB (DATA_W bits), all inputs: load-return write port.
REQ-012 The block SHALL have ports reserveEn (1 bit) and reserveAddr (ADDR_W bits), both inputs: mark a register busy for an issued load.
REQ-013 The block SHALL have port pendCount, output, $clog2(MAX_PEND+1) bits: outstanding reservations.
REQ-014 The block SHALL have port pendFull, output, 1 bit: high when pendCount == MAX_PEND.
REQ-015 The block SHALL have port ovfErr, output, 1 bit: sticky flag set on a reservation attempted while full.

Function
REQ-016 Register 0 SHALL always read 0; writes and reservations to address 0 SHALL be ignored.
REQ-017 A write with wrEnX=1 SHALL update the register at the next rising clk edge.
REQ-018 Reads SHALL bypass: if a read address equals an enabled write address in the same cycle, rdData SHALL return that write data; port B takes precedence over port A.
REQ-019 When both write ports target the same nonzero address, port B data SHALL be stored and port A data SHALL be dropped.
REQ-020 reserveEn=1 with pendFull=0 SHALL set busy[reserveAddr] and increment pendCount at the edge.
REQ-021 wrEnB=1 to a busy address SHALL clear busy and decrement pendCount at the edge.
REQ-022 wrEnB=1 to a non-busy address SHALL write the data and leave pendCount unchanged.
REQ-023 Reserve and wrEnB to the same address in one cycle SHALL write the data, leave busy set, and leave pendCount unchanged (clear followed by re-reserve).
REQ-024 Reserve and wrEnB to different addresses in one cycle SHALL apply both changes, so pendCount is unchanged; this is permitted even when pendFull=1.
REQ-025 Reserve while pendFull=1 without a simultaneous busy-clearing wrEnB SHALL be ignored and SHALL set ovfErr, which stays set until reset.
REQ-026 Reserve to an already-busy address SHALL be ignored and SHALL NOT increment pendCount.
REQ-027 rdBusy[i] SHALL equal busy[rdAddr_i] AND NOT (wrEnB AND wrAddrB == rdAddr_i), so a bypassed load return is reported not busy.
REQ-028 wrEnA to a busy address SHALL write the data and SHALL NOT clear busy.

Reset
REQ-029 When rst=1 asynchronously, all registers SHALL be cleared to 0.
REQ-030 When rst=1 asynchronously, all busy bits SHALL be cleared and pendCount SHALL be set to 0.
REQ-031 When rst=1 asynchronously, pendFull and ovfErr SHALL go to 0.
REQ-032 Reset asserted while reservations are outstanding SHALL discard them; a later wrEnB SHALL act as a plain write.

Structure
REQ-033 The shared package SHALL hold the default DATA_W, ADDR_W, MAX_PEND values and the constant ZERO_REG = 0.
REQ-034 The pending-load scoreboard (busy vector, pendCount, ovfErr) SHALL be a sub-module named regfile_scoreboard; the storage array and bypass logic stay in regfile_mp.

Verification
REQ-035 The bench SHALL cover: reset, then wrEnA r1=16, wrEnA r2=22 -> reads give r1=16, r2=22, r0=0.
REQ-036 The bench SHALL cover: wrEnA r0=99 -> r0 reads 0; same-cycle wrEnA r3=10 with rdAddr0=3 -> rdData0=10 in that cycle.
REQ-037 The bench SHALL cover: wrEnA r5=7 and wrEnB r5=9 together -> r5=9 afterwards.
REQ-038 The bench SHALL cover: reserve r4, r6, r7, r8 -> pendCount=4, pendFull=1; reserve r9 -> ignored and ovfErr=1; wrEnB r6=3 -> pendCount=3, rdBusy on r6=0.
REQ-039 The bench SHALL cover: with pendFull=1, reserve r9 and wrEnB r4=1 in one cycle -> pendCount stays 4, r9 busy, r4 not busy, r4=1.
REQ-040 The bench SHALL cover: rst asserted mid-cycle with pendCount=3 -> everything cleared immediately without waiting for a clk edge; wrEnB r7=5 afterwards -> r7=5 and pendCount=0.
